// File: rtl/sop_df_pkg.sv
// Shared constants and types for the sop_df sum-of-products block.
// The default truth table selects minterms 1, 3, 6 and 7 (y = a'c + ab).
package sop_df_pkg;

   localparam logic [7:0] TT_DEFAULT    = 8'b1100_1010;
   localparam int         CNT_W_DEFAULT = 8;

   typedef logic [2:0] minterm_idx_t;

   function automatic minterm_idx_t idx_of(input logic a, input logic b, input logic c);
      return {a, b, c};
   endfunction

endpackage

// File: rtl/sop_df_core.sv
// Combinational sum-of-products: one explicit product term per selected minterm.
module sop_df_core
   import sop_df_pkg::*;
#(
   parameter logic [7:0] TRUTH_TABLE = TT_DEFAULT
) (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);

   logic [7:0] term;

   // Minterm gi uses the true literal where its index bit is 1, the complement otherwise.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_term
         localparam logic [2:0] M = 3'(gi);
         if (TRUTH_TABLE[gi]) begin : g_on
            logic lit_a, lit_b, lit_c;
            assign lit_a = M[2] ? a : ~a;
            assign lit_b = M[1] ? b : ~b;
            assign lit_c = M[0] ? c : ~c;
            assign term[gi] = lit_a & lit_b & lit_c;
         end else begin : g_off
            assign term[gi] = 1'b0;
         end
      end
   endgenerate

   assign y = |term;

endmodule

// File: rtl/sop_df.sv
// SOP function with registered sample of result/index and a saturating hit counter.
module sop_df
   import sop_df_pkg::*;
#(
   parameter logic [7:0] TRUTH_TABLE = TT_DEFAULT,
   parameter int         CNT_W       = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             en,
   output logic             y,
   output logic             y_q,
   output logic [2:0]       idx_q,
   output logic             valid_q,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             y_smp_q,   y_smp_d;
   minterm_idx_t     idx_smp_q, idx_smp_d;
   logic             valid_smp_q, valid_smp_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   sop_df_core #(
      .TRUTH_TABLE(TRUTH_TABLE)
   ) u_core (
      .a(a),
      .b(b),
      .c(c),
      .y(y)
   );

   always_comb begin
      y_smp_d     = y_smp_q;
      idx_smp_d   = idx_smp_q;
      valid_smp_d = valid_smp_q;
      cnt_d       = cnt_q;
      if (en) begin
         y_smp_d     = y;
         idx_smp_d   = idx_of(a, b, c);
         valid_smp_d = 1'b1;
         // Counter sticks at all-ones rather than wrapping.
         if (y && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_smp_q     <= 1'b0;
         idx_smp_q   <= '0;
         valid_smp_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         y_smp_q     <= y_smp_d;
         idx_smp_q   <= idx_smp_d;
         valid_smp_q <= valid_smp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign y_q     = y_smp_q;
   assign idx_q   = idx_smp_q;
   assign valid_q = valid_smp_q;
   assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_sop_df.sv
// Directed bench for sop_df: default table, 2-bit saturating counter and XOR truth table.
module tb_sop_df;

   logic clk = 1'b0;
   logic rst, a, b, c, en;

   logic       y_d, yq_d, vq_d;
   logic [2:0] iq_d;
   logic [7:0] cnt_d;

   logic       y_s, yq_s, vq_s;
   logic [2:0] iq_s;
   logic [1:0] cnt_s;

   logic       y_x, yq_x, vq_x;
   logic [2:0] iq_x;
   logic [7:0] cnt_x;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sop_df u_def (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
      .y(y_d), .y_q(yq_d), .idx_q(iq_d), .valid_q(vq_d), .hit_cnt(cnt_d)
   );

   sop_df #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
      .y(y_s), .y_q(yq_s), .idx_q(iq_s), .valid_q(vq_s), .hit_cnt(cnt_s)
   );

   sop_df #(.TRUTH_TABLE(8'b1001_0110)) u_xor (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
      .y(y_x), .y_q(yq_x), .idx_q(iq_x), .valid_q(vq_x), .hit_cnt(cnt_x)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_abc(input logic [2:0] v);
      {a, b, c} = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] sweep_def;
      logic [1:0] sat_exp [6];
      logic [2:0] tog [5];
      logic [4:0] tog_y;
      sweep_def  = 8'b1100_1010;
      sat_exp    = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      tog        = '{3'b000, 3'b101, 3'b110, 3'b010, 3'b100};
      tog_y      = 5'b00100;  // bit k = expected default y for tog[k]

      rst = 1'b1; en = 1'b0; set_abc(3'b000);
      @(negedge clk);
      cyc();
      cyc();
      check("rst_y_q", yq_d, 0);
      check("rst_idx_q", iq_d, 0);
      check("rst_valid_q", vq_d, 0);
      check("rst_hit_cnt", cnt_d, 0);

      // Combinational sweep, registers idle.
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_abc(3'(i));
         #1;
         check($sformatf("sweep_def_y_%0d", i), y_d, sweep_def[i]);
         check($sformatf("sweep_xor_y_%0d", i), y_x, ^(3'(i)));
         $display("sweep abc=%03b y=%0b y_xor=%0b", 3'(i), y_d, y_x);
         @(negedge clk);
      end
      check("idle_valid_q", vq_d, 0);
      check("idle_hit_cnt", cnt_d, 0);

      // Reset two cycles, then a single enabled sample of 011.
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0; en = 1'b1; set_abc(3'b011);
      cyc();
      en = 1'b0;
      check("smp_y_q", yq_d, 1);
      check("smp_idx_q", iq_d, 3);
      check("smp_valid_q", vq_d, 1);
      check("smp_hit_cnt", cnt_d, 1);
      check("smp_xor_y_q", yq_x, 0);
      check("smp_xor_hit_cnt", cnt_x, 0);
      $display("sample abc=011 y_q=%0b idx_q=%0d valid_q=%0b hit_cnt=%0d", yq_d, iq_d, vq_d, cnt_d);

      // en=0: inputs toggle, registers hold, y tracks.
      for (int k = 0; k < 5; k++) begin
         set_abc(tog[k]);
         #1;
         check($sformatf("hold_y_%0d", k), y_d, tog_y[k]);
         cyc();
         check($sformatf("hold_y_q_%0d", k), yq_d, 1);
         check($sformatf("hold_idx_q_%0d", k), iq_d, 3);
         check($sformatf("hold_valid_q_%0d", k), vq_d, 1);
         check($sformatf("hold_hit_cnt_%0d", k), cnt_d, 1);
         $display("hold abc=%03b y=%0b y_q=%0b hit_cnt=%0d", tog[k], y_d, yq_d, cnt_d);
      end

      // Mid-run reset with en=1 and abc=110: reset wins, y unaffected.
      rst = 1'b1; en = 1'b1; set_abc(3'b110);
      #1;
      check("midrst_y_before", y_d, 1);
      cyc();
      check("midrst_y_q", yq_d, 0);
      check("midrst_idx_q", iq_d, 0);
      check("midrst_valid_q", vq_d, 0);
      check("midrst_hit_cnt", cnt_d, 0);
      check("midrst_sat_cnt", cnt_s, 0);
      check("midrst_y", y_d, 1);
      $display("midrst y=%0b y_q=%0b idx_q=%0d valid_q=%0b hit_cnt=%0d", y_d, yq_d, iq_d, vq_d, cnt_d);

      // abc=111 held with en=1 for 6 cycles: 2-bit counter saturates at 3.
      rst = 1'b0; set_abc(3'b111);
      for (int k = 0; k < 6; k++) begin
         cyc();
         check($sformatf("sat_cnt_%0d", k), cnt_s, sat_exp[k]);
         check($sformatf("wide_cnt_%0d", k), cnt_d, k + 1);
         check($sformatf("xor_cnt_%0d", k), cnt_x, k + 1);
         $display("sat cycle=%0d hit_cnt2=%0d hit_cnt8=%0d", k, cnt_s, cnt_d);
      end
      check("sat_y_q", yq_d, 1);
      check("sat_idx_q", iq_d, 7);
      check("sat_valid_q", vq_s, 1);

      // Enabled sample of a y=0 minterm must not count.
      set_abc(3'b100);
      cyc();
      check("zero_y_q", yq_d, 0);
      check("zero_idx_q", iq_d, 4);
      check("zero_hit_cnt", cnt_d, 6);

      // Final reset with en held high clears everything including the saturated counter.
      rst = 1'b1;
      cyc();
      check("final_sat_cnt", cnt_s, 0);
      check("final_valid_q", vq_d, 0);
      rst = 1'b0; en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sop_df.md
SOP_DF -- requirements
Module: sop_df

Interface
REQ-001 Parameter TRUTH_TABLE, default 8'b1100_1010, sets y for minterm index {a,b,c} (bit i = output for index i).
REQ-002 Parameter CNT_W, default 8, sets the width of hit_cnt.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  1  function input, MSB of the minterm index.
REQ-006 b  input  1  function input, middle bit of the minterm index.
REQ-007 c  input  1  function input, LSB of the minterm index.
REQ-008 en  input  1  sample enable for the registered outputs and counter.
REQ-009 y  output  1  combinational sum-of-products result.
REQ-010 y_q  output  1  registered copy of y.
REQ-011 idx_q  output  3  registered minterm index {a,b,c}.
REQ-012 valid_q  output  1  high when y_q/idx_q hold a sample taken since reset.
REQ-013 hit_cnt  output  CNT_W  saturating count of sampled cycles with y=1.

Function
REQ-014 y SHALL equal the OR of all product terms whose TRUTH_TABLE bit is set; the default gives y = a'b'c + a'bc + abc' + abc (= a'c + ab).
REQ-015 y SHALL be purely combinational, zero latency, and independent of clk, rst and en.
REQ-016 y SHALL settle within the same delta/time step as any change on a, b or c; no latch or glitch-holding logic.
REQ-017 On a rising clk edge with rst=0 and en=1: y_q<=y, idx_q<={a,b,c}, valid_q<=1.
REQ-018 On a rising clk edge with rst=0 and en=0: y_q, idx_q and valid_q SHALL hold their values.
REQ-019 hit_cnt SHALL increment by 1 on each edge with rst=0, en=1 and y=1; otherwise it SHALL hold.
REQ-020 hit_cnt SHALL saturate at 2^CNT_W-1 and not wrap around.
REQ-021 Registered outputs SHALL have a latency of exactly one clk cycle from the sampled inputs.
REQ-022 X/Z on a, b or c SHALL NOT be required to resolve; the 8 legal 0/1 combinations are fully specified.

Reset
REQ-023 When rst=1 at a rising clk edge: y_q=0, idx_q=3'b000, valid_q=0, hit_cnt=0, regardless of en.
REQ-024 rst SHALL have priority over en, including when asserted mid-operation.
REQ-025 rst SHALL NOT affect the combinational y.

Structure
REQ-026 Package sop_df_pkg SHALL hold the TRUTH_TABLE default constant, the CNT_W default, and a 3-bit minterm-index typedef.
REQ-027 A combinational sub-module sop_df_core (inputs a,b,c; output y; TRUTH_TABLE parameter) SHALL implement the SOP, with the registers in sop_df.
REQ-028 The SOP SHALL be written as explicit product terms (dataflow), not a case-table memory.

Verification
REQ-029 Sweep {a,b,c} through 000..111 every 10 time units with rst=0 -> y = 0,1,0,1,0,0,1,1.
REQ-030 rst=1 for 2 cycles, then en=1 with abc=011 -> y_q=1, idx_q=3, valid_q=1 one cycle later, and hit_cnt=1.
REQ-031 en=0 and abc toggling over 5 cycles -> y_q, idx_q, valid_q and hit_cnt are unchanged while y tracks the inputs.
REQ-032 CNT_W=2, en=1, abc=111 held for 6 cycles -> hit_cnt reads 1,2,3,3,3,3.
REQ-033 rst=1 asserted mid-run with en=1 and abc=110 -> all registered outputs are 0 on the next edge, and y stays 1.
REQ-034 TRUTH_TABLE=8'b1001_0110 with a full sweep -> y = a^b^c for all 8 combinations.
